des_cbc_ctrl: RTL and testbench
===============================

# des_cbc_ctrl

CBC-mode sequencer wrapped around the team's combinational DES encrypt core (`DES_top`) and decrypt core (`DES_decrypt`). It accepts a key, an IV and a stream of 64-bit blocks over a valid/ready handshake. It drives the cores through registered inputs, waits a programmable settle time, applies CBC chaining and returns each result over a second valid/ready handshake. Both cores are instantiated by the parent; this block owns only their inputs and sequencing.

## Interface
Parameters:
- `CORE_WAIT`, default 2: cycles the core outputs settle before capture; legal range 1..15.

Ports:
- `CLK`  in  1: clock, rising edge.
- `RST_N`  in  1: reset, synchronous, active-low.
- `START`  in  1: single-cycle pulse. Loads `KEY_IN`, `IV_IN` and `MODE`. Honoured only in IDLE.
- `MODE`  in  1: 0 = encrypt, 1 = decrypt.
- `KEY_IN`  in  64: DES key, including parity bits.
- `IV_IN`  in  64: CBC initialisation vector.
- `IN_VALID`  in  1: block offered.
- `IN_READY`  out  1: block accepted when both `IN_VALID` and `IN_READY` are high.
- `IN_DATA`  in  64: block to process.
- `IN_LAST`  in  1: final block of the message.
- `OUT_VALID`  out  1: result available.
- `OUT_READY`  in  1: consumer accepts the result.
- `OUT_DATA`  out  64: result block.
- `OUT_LAST`  out  1: copy of `IN_LAST` for this block.
- `BUSY`  out  1: high in every state except IDLE.
- `CORE_KEY`  out  64: registered key, driven to both cores.
- `CORE_ENC_IN`  out  64: registered input to `DES_top` PLAIN_TEXT.
- `CORE_ENC_OUT`  in  64: `DES_top` CIPHER_TEXT.
- `CORE_DEC_IN`  out  64: registered input to `DES_decrypt` CIPHER_TEXT.
- `CORE_DEC_OUT`  in  64: `DES_decrypt` PLAIN_TEXT.

## Operation
- States: IDLE, ACCEPT, WAIT, OUTPUT. Outputs are decoded from state: `IN_READY` is high only in ACCEPT, `OUT_VALID` only in OUTPUT.
- IDLE:
  - `START` loads CORE_KEY←KEY_IN, CHAIN←IV_IN and mode_r←MODE, then moves to ACCEPT.
  - `IN_VALID` is ignored.
- ACCEPT, on the `IN_VALID` handshake:
  - Load DIN←IN_DATA and last_r←IN_LAST.
  - Encrypt: CORE_ENC_IN←IN_DATA^CHAIN.
  - Decrypt: CORE_DEC_IN←IN_DATA.
  - Load cnt←CORE_WAIT-1, then move to WAIT.
- WAIT:
  - While cnt≠0, decrement cnt.
  - When cnt=0, capture the result and move to OUTPUT.
  - Encrypt capture: OUT_DATA←CORE_ENC_OUT; CHAIN←CORE_ENC_OUT.
  - Decrypt capture: OUT_DATA←CORE_DEC_OUT^CHAIN; CHAIN←DIN.
  - OUT_LAST←last_r.
- OUTPUT:
  - Hold `OUT_DATA` and `OUT_LAST` stable until `OUT_READY`.
  - On the handshake, go to IDLE if last_r is set, otherwise to ACCEPT.
- Core inputs and `CORE_KEY` change only on a `START` or an input handshake, so they stay stable throughout WAIT.
- `START` outside IDLE is ignored; `MODE`, `KEY_IN` and `IV_IN` are sampled only with `START`.
- After a message ends (return to IDLE), CHAIN is not preserved across messages: the next `START` reloads it.

## Timing
- Reset, sampled at a rising edge with `RST_N`=0:
  - state←IDLE.
  - `IN_READY`, `OUT_VALID`, `OUT_LAST` and `BUSY` ← 0.
  - `OUT_DATA`, `CORE_KEY`, `CORE_ENC_IN`, `CORE_DEC_IN`, CHAIN, DIN and cnt ← 0.
- Reset mid-operation abandons the block. No output handshake occurs, and `OUT_VALID` is 0 from the next edge.
- `START` at edge s: `IN_READY`=1 and `BUSY`=1 after edge s.
- Input handshake at edge k:
  - Core inputs are updated after edge k.
  - Capture happens at edge k+CORE_WAIT.
  - `OUT_VALID`=1 after edge k+CORE_WAIT.
- Output handshake at edge m: `IN_READY`=1 after edge m (non-last block); `OUT_VALID`=0 after edge m.
- Minimum block period with `OUT_READY` tied high: CORE_WAIT+2 cycles.
- `IN_READY` and `OUT_VALID` are never high in the same cycle.

## Test plan
- **ECB equivalence (encrypt):** CORE_WAIT=2. `START` with MODE=0, KEY_IN=133457799BBCDFF1, IV_IN=0. Send 0123456789ABCDEF with IN_LAST=1.
  - Required: OUT_DATA=85E813540F0AB405 and OUT_LAST=1, with OUT_VALID rising 2 cycles after the input handshake.
  - Required: BUSY=0 after the output handshake.
- **Decrypt:** same key, IV=0, MODE=1. Send 85E813540F0AB405.
  - Required: OUT_DATA=0123456789ABCDEF.
- **Two-block CBC chaining:** IV=0. Send 0123456789ABCDEF twice.
  - Required: block 0 gives OUT_DATA=85E813540F0AB405.
  - Required: for block 1, CORE_ENC_IN=84CB563386A179EA.
  - Required: decrypting both ciphertexts with IV=0 returns 0123456789ABCDEF twice.
- **Backpressure:** hold OUT_READY=0 for 5 cycles while in OUTPUT.
  - Required: OUT_VALID stays 1, OUT_DATA and OUT_LAST are unchanged, IN_READY stays 0.
  - Required: on the first cycle with OUT_READY=1, the handshake completes and the state returns to ACCEPT.
- **Reset and ignored `START`:** pulse START with a different key during WAIT.
  - Required: CORE_KEY is unchanged.
  - Then assert RST_N=0 for one edge in WAIT. Required: all outputs are 0 after that edge and no OUT_VALID pulse appears.
- **Settle parameter:** with CORE_WAIT=1 and CORE_WAIT=5, run the ECB case.
  - Required: OUT_VALID rises exactly 1 or 5 cycles, respectively, after the input handshake, and OUT_DATA is correct in both runs.

Source files
------------

// File: rtl/des_cbc_ctrl.sv
// CBC-mode sequencer for the combinational DES encrypt/decrypt cores.
// Registers core inputs, waits CORE_WAIT cycles for settling, applies chaining and hands results out.
module des_cbc_ctrl #(
    parameter int unsigned CORE_WAIT = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic        MODE,
    input  logic [63:0] KEY_IN,
    input  logic [63:0] IV_IN,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [63:0] IN_DATA,
    input  logic        IN_LAST,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [63:0] OUT_DATA,
    output logic        OUT_LAST,
    output logic        BUSY,
    output logic [63:0] CORE_KEY,
    output logic [63:0] CORE_ENC_IN,
    input  logic [63:0] CORE_ENC_OUT,
    output logic [63:0] CORE_DEC_IN,
    input  logic [63:0] CORE_DEC_OUT
);

    localparam int unsigned BLK_W = 64;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CORE_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_WAIT,
        S_OUTPUT
    } state_t;

    state_t           state;
    logic [BLK_W-1:0] chain;
    logic [BLK_W-1:0] din;
    logic [CNT_W-1:0] cnt;
    logic             mode_r;
    logic             last_r;

    // Sequencer; handshake flags are registered alongside every state change.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            IN_READY    <= 1'b0;
            OUT_VALID   <= 1'b0;
            OUT_LAST    <= 1'b0;
            BUSY        <= 1'b0;
            OUT_DATA    <= '0;
            CORE_KEY    <= '0;
            CORE_ENC_IN <= '0;
            CORE_DEC_IN <= '0;
            chain       <= '0;
            din         <= '0;
            cnt         <= '0;
            mode_r      <= 1'b0;
            last_r      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (START) begin
                        CORE_KEY <= KEY_IN;
                        chain    <= IV_IN;
                        mode_r   <= MODE;
                        IN_READY <= 1'b1;
                        BUSY     <= 1'b1;
                        state    <= S_ACCEPT;
                    end
                end

                S_ACCEPT: begin
                    if (IN_VALID) begin
                        din    <= IN_DATA;
                        last_r <= IN_LAST;
                        if (mode_r) begin
                            CORE_DEC_IN <= IN_DATA;
                        end else begin
                            CORE_ENC_IN <= IN_DATA ^ chain;
                        end
                        cnt      <= CNT_INIT;
                        IN_READY <= 1'b0;
                        state    <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // Encrypt chains on the ciphertext produced; decrypt on the ciphertext consumed.
                        if (mode_r) begin
                            OUT_DATA <= CORE_DEC_OUT ^ chain;
                            chain    <= din;
                        end else begin
                            OUT_DATA <= CORE_ENC_OUT;
                            chain    <= CORE_ENC_OUT;
                        end
                        OUT_LAST  <= last_r;
                        OUT_VALID <= 1'b1;
                        state     <= S_OUTPUT;
                    end
                end

                S_OUTPUT: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        if (last_r) begin
                            BUSY  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            IN_READY <= 1'b1;
                            state    <= S_ACCEPT;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// Scoreboard bench for des_cbc_ctrl with a behavioural DES standing in for the cores.
module tb_des_cbc_ctrl;

    localparam logic [63:0] K0  = 64'h133457799BBCDFF1;
    localparam logic [63:0] K1  = 64'hFEDCBA9876543210;
    localparam logic [63:0] P0  = 64'h0123456789ABCDEF;
    localparam logic [63:0] C0  = 64'h85E813540F0AB405;
    localparam logic [63:0] X1  = 64'h84CB563386A179EA;

    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                  10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int SHIFT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    // Textbook DES, bit 1 = MSB; decrypt runs the subkeys in reverse.
    function automatic logic [63:0] des_model(input logic [63:0] key, input logic [63:0] blk,
                                              input logic dec);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] sk [16];
        logic [63:0] ipv, pre, res;
        logic [31:0] l, r, f, sout, tmp;
        logic [47:0] ex;
        logic [5:0]  six;
        int          row, col;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int rnd = 0; rnd < 16; rnd++) begin
            for (int s = 0; s < SHIFT_T[rnd]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) sk[rnd][47-i] = cd[56-PC2_T[i]];
        end
        for (int i = 0; i < 64; i++) ipv[63-i] = blk[64-IP_T[i]];
        l = ipv[63:32];
        r = ipv[31:0];
        for (int rnd = 0; rnd < 16; rnd++) begin
            for (int i = 0; i < 48; i++) ex[47-i] = r[32-E_T[i]];
            ex = ex ^ sk[dec ? 15 - rnd : rnd];
            for (int s = 0; s < 8; s++) begin
                six = ex[47-6*s -: 6];
                row = int'({six[5], six[0]});
                col = int'(six[4:1]);
                sout[31-4*s -: 4] = 4'(SBOX[s][row*16+col]);
            end
            for (int i = 0; i < 32; i++) f[31-i] = sout[32-P_T[i]];
            tmp = r;
            r   = l ^ f;
            l   = tmp;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) res[63-i] = pre[64-FP_T[i]];
        return res;
    endfunction

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, start_s, mode, in_valid, in_valid_s, in_last, out_ready, out_ready_s;
    logic [63:0] key_in, iv_in, in_data;

    logic        in_ready, out_valid, out_last, busy;
    logic [63:0] out_data, core_key, core_enc_in, core_enc_out, core_dec_in, core_dec_out;
    logic        in_ready_1, out_valid_1, out_last_1, busy_1;
    logic [63:0] out_data_1, core_key_1, core_enc_in_1, core_enc_out_1, core_dec_in_1, core_dec_out_1;
    logic        in_ready_5, out_valid_5, out_last_5, busy_5;
    logic [63:0] out_data_5, core_key_5, core_enc_in_5, core_enc_out_5, core_dec_in_5, core_dec_out_5;

    assign core_enc_out   = des_model(core_key, core_enc_in, 1'b0);
    assign core_dec_out   = des_model(core_key, core_dec_in, 1'b1);
    assign core_enc_out_1 = des_model(core_key_1, core_enc_in_1, 1'b0);
    assign core_dec_out_1 = des_model(core_key_1, core_dec_in_1, 1'b1);
    assign core_enc_out_5 = des_model(core_key_5, core_enc_in_5, 1'b0);
    assign core_dec_out_5 = des_model(core_key_5, core_dec_in_5, 1'b1);

    des_cbc_ctrl #(.CORE_WAIT(2)) u_dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .MODE(mode), .KEY_IN(key_in), .IV_IN(iv_in),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data), .IN_LAST(in_last),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data), .OUT_LAST(out_last),
        .BUSY(busy), .CORE_KEY(core_key), .CORE_ENC_IN(core_enc_in), .CORE_ENC_OUT(core_enc_out),
        .CORE_DEC_IN(core_dec_in), .CORE_DEC_OUT(core_dec_out));

    des_cbc_ctrl #(.CORE_WAIT(1)) u_dut_w1 (
        .CLK(clk), .RST_N(rst_n), .START(start_s), .MODE(mode), .KEY_IN(key_in), .IV_IN(iv_in),
        .IN_VALID(in_valid_s), .IN_READY(in_ready_1), .IN_DATA(in_data), .IN_LAST(in_last),
        .OUT_VALID(out_valid_1), .OUT_READY(out_ready_s), .OUT_DATA(out_data_1), .OUT_LAST(out_last_1),
        .BUSY(busy_1), .CORE_KEY(core_key_1), .CORE_ENC_IN(core_enc_in_1), .CORE_ENC_OUT(core_enc_out_1),
        .CORE_DEC_IN(core_dec_in_1), .CORE_DEC_OUT(core_dec_out_1));

    des_cbc_ctrl #(.CORE_WAIT(5)) u_dut_w5 (
        .CLK(clk), .RST_N(rst_n), .START(start_s), .MODE(mode), .KEY_IN(key_in), .IV_IN(iv_in),
        .IN_VALID(in_valid_s), .IN_READY(in_ready_5), .IN_DATA(in_data), .IN_LAST(in_last),
        .OUT_VALID(out_valid_5), .OUT_READY(out_ready_s), .OUT_DATA(out_data_5), .OUT_LAST(out_last_5),
        .BUSY(busy_5), .CORE_KEY(core_key_5), .CORE_ENC_IN(core_enc_in_5), .CORE_ENC_OUT(core_enc_out_5),
        .CORE_DEC_IN(core_dec_in_5), .CORE_DEC_OUT(core_dec_out_5));

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } exp_t;

    exp_t        sb_q [$];
    logic [63:0] mdl_key, mdl_chain;
    logic        mdl_mode;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t pop_exp();
        exp_t e;
        e = '0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        return e;
    endfunction

    task automatic start_msg(input logic m, input logic [63:0] k, input logic [63:0] iv);
        mode = m; key_in = k; iv_in = iv; start = 1'b1;
        tick();
        start = 1'b0;
        mdl_key = k; mdl_chain = iv; mdl_mode = m;
    endtask

    // Waits (bounded) for IN_READY, performs the handshake and pushes the CBC-reference result.
    task automatic send_blk(input logic [63:0] d, input logic l);
        int   n;
        exp_t e;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin tick(); n++; end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1; in_data = d; in_last = l;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        if (mdl_mode) begin
            e.data = des_model(mdl_key, d, 1'b1) ^ mdl_chain;
            mdl_chain = d;
        end else begin
            e.data = des_model(mdl_key, d ^ mdl_chain, 1'b0);
            mdl_chain = e.data;
        end
        e.last = l;
        sb_q.push_back(e);
    endtask

    task automatic recv_blk(output logic [63:0] d, output logic l, output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin tick(); lat++; end
        d = out_data; l = out_last;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_vec++;
        if ({in_ready, out_valid, out_last, busy} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_flags: ready/valid/last/busy=%b required 0000",
                     {in_ready, out_valid, out_last, busy});
        end
        n_vec++;
        if ({out_data, core_key, core_enc_in, core_dec_in} !== 256'b0) begin
            n_err++;
            $display("FAIL reset_data: out=%h key=%h enc=%h dec=%h required all 0",
                     out_data, core_key, core_enc_in, core_dec_in);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ecb_encrypt();
        logic [63:0] d;
        logic        l;
        int          lat;
        exp_t        e;
        start_msg(1'b0, K0, 64'h0);
        n_vec++;
        if ({in_ready, busy} !== 2'b11) begin
            n_err++;
            $display("FAIL ecb_start: ready/busy=%b required 11", {in_ready, busy});
        end
        send_blk(P0, 1'b1);
        recv_blk(d, l, lat);
        e = pop_exp();
        n_vec++;
        if (lat !== 2) begin
            n_err++;
            $display("FAIL ecb_latency: %0d cycles required 2", lat);
        end
        n_vec++;
        if (d !== C0 || d !== e.data || l !== 1'b1) begin
            n_err++;
            $display("FAIL ecb_data: data=%h last=%b required %h/%h last 1", d, l, C0, e.data);
        end
        n_vec++;
        if ({busy, out_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL ecb_idle: busy/valid=%b required 00", {busy, out_valid});
        end
    endtask

    task automatic test_decrypt();
        logic [63:0] d;
        logic        l;
        int          lat;
        exp_t        e;
        start_msg(1'b1, K0, 64'h0);
        send_blk(C0, 1'b1);
        n_vec++;
        if (core_dec_in !== C0) begin
            n_err++;
            $display("FAIL dec_core_in: %h required %h", core_dec_in, C0);
        end
        recv_blk(d, l, lat);
        e = pop_exp();
        n_vec++;
        if (d !== P0 || d !== e.data || l !== 1'b1) begin
            n_err++;
            $display("FAIL dec_data: data=%h last=%b required %h last 1", d, l, P0);
        end
    endtask

    task automatic test_cbc_chain();
        logic [63:0] c [2];
        logic [63:0] d;
        logic        l;
        int          lat;
        exp_t        e;
        start_msg(1'b0, K0, 64'h0);
        send_blk(P0, 1'b0);
        recv_blk(c[0], l, lat);
        e = pop_exp();
        n_vec++;
        if (c[0] !== C0 || c[0] !== e.data || l !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL cbc_blk0: data=%h last=%b ready=%b required %h last 0 ready 1",
                     c[0], l, in_ready, C0);
        end
        send_blk(P0, 1'b1);
        n_vec++;
        if (core_enc_in !== X1) begin
            n_err++;
            $display("FAIL cbc_core_in: %h required %h", core_enc_in, X1);
        end
        recv_blk(c[1], l, lat);
        e = pop_exp();
        n_vec++;
        if (c[1] !== e.data || l !== 1'b1) begin
            n_err++;
            $display("FAIL cbc_blk1: data=%h last=%b required %h last 1", c[1], l, e.data);
        end
        start_msg(1'b1, K0, 64'h0);
        for (int i = 0; i < 2; i++) begin
            send_blk(c[i], i == 1);
            recv_blk(d, l, lat);
            e = pop_exp();
            n_vec++;
            if (d !== P0 || d !== e.data) begin
                n_err++;
                $display("FAIL cbc_dec%0d: data=%h required %h", i, d, P0);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] d, d2;
        logic        l, l2;
        int          n;
        exp_t        e;
        start_msg(1'b0, K0, 64'h0);
        send_blk(64'hDEADBEEFCAFEF00D, 1'b0);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin tick(); n++; end
        d = out_data; l = out_last;
        e = pop_exp();
        n_vec++;
        if (d !== e.data || l !== 1'b0) begin
            n_err++;
            $display("FAIL bp_data: data=%h last=%b required %h last 0", d, l, e.data);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== d || out_last !== l || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: valid=%b data=%h last=%b ready=%b required 1/%h/%b/0",
                         i, out_valid, out_data, out_last, in_ready, d, l);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++;
        if ({out_valid, in_ready, busy} !== 3'b011) begin
            n_err++;
            $display("FAIL bp_release: valid/ready/busy=%b required 011", {out_valid, in_ready, busy});
        end
        send_blk(64'h0011223344556677, 1'b1);
        recv_blk(d2, l2, n);
        e = pop_exp();
        n_vec++;
        if (d2 !== e.data || l2 !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_last: data=%h last=%b busy=%b required %h last 1 busy 0",
                     d2, l2, busy, e.data);
        end
    endtask

    task automatic test_ignored_start_reset();
        bit seen;
        start_msg(1'b0, K0, 64'h0);
        send_blk(P0, 1'b1);
        key_in = K1; start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if (core_key !== K0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wait_start: key=%h valid=%b required %h valid 0", core_key, out_valid, K0);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_vec++;
        if ({in_ready, out_valid, out_last, busy} !== 4'b0 ||
            {out_data, core_key, core_enc_in, core_dec_in} !== 256'b0) begin
            n_err++;
            $display("FAIL wait_reset: flags=%b out=%h key=%h enc=%h dec=%h required all 0",
                     {in_ready, out_valid, out_last, busy}, out_data, core_key, core_enc_in, core_dec_in);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL wait_no_valid: out_valid pulse observed=%b required 0", seen);
        end
        sb_q.delete();
    endtask

    task automatic test_settle();
        int          lat1, lat5;
        logic [63:0] d1, d5, ref_c;
        ref_c = des_model(K0, P0, 1'b0);
        out_ready_s = 1'b1;
        mode = 1'b0; key_in = K0; iv_in = 64'h0; start_s = 1'b1;
        tick();
        start_s = 1'b0;
        n_vec++;
        if ({in_ready_1, in_ready_5} !== 2'b11) begin
            n_err++;
            $display("FAIL settle_start: ready w1/w5=%b required 11", {in_ready_1, in_ready_5});
        end
        in_data = P0; in_last = 1'b1; in_valid_s = 1'b1;
        tick();
        in_valid_s = 1'b0; in_last = 1'b0;
        lat1 = -1; lat5 = -1; d1 = '0; d5 = '0;
        for (int n = 1; n <= 12; n++) begin
            if (lat1 < 0 && out_valid_1 === 1'b1) begin lat1 = n - 1; d1 = out_data_1; end
            if (lat5 < 0 && out_valid_5 === 1'b1) begin lat5 = n - 1; d5 = out_data_5; end
            tick();
        end
        n_vec++;
        if (lat1 !== 1 || lat5 !== 5) begin
            n_err++;
            $display("FAIL settle_latency: w1=%0d w5=%0d required 1 and 5", lat1, lat5);
        end
        n_vec++;
        if (d1 !== C0 || d5 !== C0 || d1 !== ref_c) begin
            n_err++;
            $display("FAIL settle_data: w1=%h w5=%h required %h", d1, d5, C0);
        end
        n_vec++;
        if ({busy_1, busy_5} !== 2'b00) begin
            n_err++;
            $display("FAIL settle_idle: busy w1/w5=%b required 00", {busy_1, busy_5});
        end
        out_ready_s = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_s = 1'b0; mode = 1'b0;
        in_valid = 1'b0; in_valid_s = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; out_ready_s = 1'b0;
        key_in = '0; iv_in = '0; in_data = '0;
        mdl_key = '0; mdl_chain = '0; mdl_mode = 1'b0;
        test_reset();
        test_ecb_encrypt();
        test_decrypt();
        test_cbc_chain();
        test_backpressure();
        test_ignored_start_reset();
        test_settle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Protocol invariant, sampled away from the active edge on every cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && in_ready === 1'b1 && out_valid === 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_valid_overlap: in_ready=1 out_valid=1 required not both");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
